bpsk_dump_frame_ctrl: RTL and testbench

//   Integrate-and-dump sequencer and frame controller for the BPSK receive path.
//   - Input: the per-sample I-branch product (received sample x carrier).
//   - Accumulates the product over one symbol period, then dumps.
//   - Slices each symbol to a bit.
//   - Hunts for a fixed preamble, then delivers FRAME_BITS payload bits downstream

---
 rtl/bpsk_pkg.sv | 22 ++
 rtl/bpsk_bit_fifo2.sv | 75 +++++++
 rtl/bpsk_dump_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_bpsk_dump_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared types and defaults for the BPSK integrate-and-dump frame controller
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  localparam int unsigned DEF_SPS        = 16;
  localparam int unsigned DEF_PROD_W     = 24;
  localparam int unsigned DEF_ACC_W      = 32;
  localparam int unsigned DEF_PRE_LEN    = 8;
  localparam int unsigned DEF_FRAME_BITS = 64;
  localparam logic [7:0]  DEF_PREAMBLE   = 8'hA5;

  // Symmetric saturation limits for the default accumulator width; the most
  // negative two's-complement code is excluded so +/- limits mirror each other.
  localparam logic signed [DEF_ACC_W-1:0] DEF_ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] DEF_ACC_MIN = {1'b1, {(DEF_ACC_W-2){1'b0}}, 1'b1};

endpackage

// File: rtl/bpsk_bit_fifo2.sv
// rtl/bpsk_bit_fifo2.sv - 2-entry valid/ready bit buffer that drops (and flags) pushes when full
module bpsk_bit_fifo2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic s_tvalid_i,
  input  logic s_tdata_i,
  input  logic m_tready_i,
  output logic m_tvalid_o,
  output logic m_tdata_o,
  output logic drop_o
);

  logic [1:0] cnt_q, cnt_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic       pop;

  assign m_tvalid_o = (cnt_q != 2'd0);
  assign m_tdata_o  = head_q;
  assign pop        = m_tvalid_o & m_tready_i;
  assign drop_o     = s_tvalid_i & (cnt_q == 2'd2) & ~pop & ~flush_i;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (s_tvalid_i) begin
            head_d = s_tdata_i;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (s_tvalid_i && pop) begin
            head_d = s_tdata_i;
          end else if (pop) begin
            cnt_d = 2'd0;
          end else if (s_tvalid_i) begin
            tail_d = s_tdata_i;
            cnt_d  = 2'd2;
          end
        end
        2'd2: begin
          // A simultaneous pop frees the slot the incoming bit needs.
          if (pop) begin
            head_d = tail_q;
            if (s_tvalid_i) tail_d = s_tdata_i;
            else            cnt_d  = 2'd1;
          end
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/bpsk_dump_frame_ctrl.sv
// rtl/bpsk_dump_frame_ctrl.sv - symbol-aligned integrate-and-dump, slicer, preamble hunt and payload framing
module bpsk_dump_frame_ctrl
  import bpsk_pkg::*;
#(
  parameter int unsigned                SPS        = DEF_SPS,
  parameter int unsigned                PROD_W     = DEF_PROD_W,
  parameter int unsigned                ACC_W      = DEF_ACC_W,
  parameter int unsigned                PRE_LEN    = DEF_PRE_LEN,
  parameter logic [PRE_LEN-1:0]         PREAMBLE   = PRE_LEN'(DEF_PREAMBLE),
  parameter int unsigned                FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              frame_start,
  output logic              frame_active,
  output logic              overflow,
  output logic [1:0]        state_o
);

  localparam int unsigned SYM_W = $clog2(SPS);
  localparam int unsigned PAY_W = $clog2(FRAME_BITS);
  localparam int unsigned EXT_W = ACC_W + 1 - PROD_W;

  localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic [SYM_W-1:0]         sym_q;
  logic [PRE_LEN-1:0]       shreg_q, shreg_d, shreg_shift;
  logic [PAY_W-1:0]         pay_q, pay_d;
  logic                     dec_q, dec_vld_q;
  logic                     fs_q, fs_d;
  logic                     ovf_q;
  logic                     push;
  logic                     fifo_drop;

  logic                     active;
  logic                     dump;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W:0]    sum_clamp;
  logic signed [ACC_W-1:0]  sum_sat;
  logic                     slice;

  // One-bit headroom on the sum makes overflow detection a plain compare.
  assign active    = enable && (state_q != ST_IDLE);
  assign dump      = active && prod_valid && (sym_q == SYM_W'(SPS - 1));
  assign sum_wide  = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod_in[PROD_W-1]}}, prod_in};
  assign sum_clamp = (sum_wide > SAT_MAX) ? SAT_MAX :
                     (sum_wide < SAT_MIN) ? SAT_MIN : sum_wide;
  assign sum_sat   = sum_clamp[ACC_W-1:0];
  assign slice     = ~sum_sat[ACC_W-1] & (|sum_sat);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      acc_q     <= '0;
      sym_q     <= '0;
      dec_q     <= 1'b0;
      dec_vld_q <= 1'b0;
    end else begin
      dec_vld_q <= dump;
      if (dump) begin
        dec_q <= slice;
        acc_q <= '0;
        sym_q <= '0;
      end else if (active && prod_valid) begin
        acc_q <= sum_sat;
        sym_q <= sym_q + SYM_W'(1);
      end
    end
  end

  assign shreg_shift = {shreg_q[PRE_LEN-2:0], dec_q};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pay_d   = pay_q;
    fs_d    = 1'b0;
    push    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      pay_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (dec_vld_q) begin
            shreg_d = shreg_shift;
            if (shreg_shift == PREAMBLE) begin
              state_d = ST_PAYLOAD;
              fs_d    = 1'b1;
              pay_d   = '0;
              shreg_d = '0;
            end
          end
        end
        ST_PAYLOAD: begin
          // Dropped bits still count, so frame length is fixed in symbols.
          if (dec_vld_q) begin
            push = 1'b1;
            if (pay_q == PAY_W'(FRAME_BITS - 1)) begin
              state_d = ST_HUNT;
              pay_d   = '0;
            end else begin
              pay_d = pay_q + PAY_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      pay_q   <= '0;
      fs_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pay_q   <= pay_d;
      fs_q    <= fs_d;
      ovf_q   <= enable ? (ovf_q | fifo_drop) : 1'b0;
    end
  end

  bpsk_bit_fifo2 u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (~enable),
    .s_tvalid_i (push),
    .s_tdata_i  (dec_q),
    .m_tready_i (bit_ready),
    .m_tvalid_o (bit_valid),
    .m_tdata_o  (bit_out),
    .drop_o     (fifo_drop)
  );

  assign frame_start  = fs_q;
  assign frame_active = (state_q == ST_PAYLOAD);
  assign overflow     = ovf_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_bpsk_dump_frame_ctrl.sv
// tb/tb_bpsk_dump_frame_ctrl.sv - randomized scoreboard bench for bpsk_dump_frame_ctrl
module tb_bpsk_dump_frame_ctrl;

  localparam int SPS  = 16;
  localparam int PW   = 24;
  localparam int AW   = 24;
  localparam longint LIM = (longint'(1) << (AW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] prod_in = '0;
  logic          prod_valid = 1'b0;
  logic          bit_out, bit_valid, frame_start, frame_active, overflow;
  logic          bit_ready = 1'b0;
  logic [1:0]    state_o;

  bpsk_dump_frame_ctrl #(
    .SPS(SPS), .PROD_W(PW), .ACC_W(AW), .PRE_LEN(8), .PREAMBLE(8'hA5), .FRAME_BITS(64)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .prod_in(prod_in), .prod_valid(prod_valid),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .frame_start(frame_start), .frame_active(frame_active), .overflow(overflow),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit sb[$];
  int fs_seen = 0;
  int exp_fs = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 held low

  // reference model state: plain bit-level view of the receiver
  bit       m_hunt = 1'b1;
  bit [7:0] m_win = '0;
  int       m_pay = 0;
  int       m_occ = 0;
  longint   samp[SPS];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_symbol();
    longint acc = 0;
    for (int i = 0; i < SPS; i++) begin
      acc += samp[i];
      if (acc > LIM) acc = LIM;
      if (acc < -LIM) acc = -LIM;
    end
    return acc > 0;
  endfunction

  task automatic model_bit(input bit d);
    if (m_hunt) begin
      m_win = {m_win[6:0], d};
      if (m_win == 8'hA5) begin
        m_hunt = 1'b0;
        m_pay  = 0;
        m_win  = '0;
        exp_fs++;
      end
    end else begin
      if (!(rdy_mode == 2 && m_occ >= 2)) begin
        sb.push_back(d);
        if (rdy_mode == 2) m_occ++;
      end
      m_pay++;
      if (m_pay == 64) m_hunt = 1'b1;
    end
  endtask

  // mode: 0 noisy clean, 1 exact +/-100, 2 zeros, 3 max positive, 4 full random
  task automatic send_symbol(input int mode, input bit b);
    bit d;
    for (int i = 0; i < SPS; i++) begin
      case (mode)
        0: samp[i] = (b ? 1 : -1) * longint'($urandom_range(50, 3000)) + longint'($urandom_range(0, 80)) - 40;
        1: samp[i] = b ? 100 : -100;
        2: samp[i] = 0;
        3: samp[i] = LIM;
        default: samp[i] = longint'($urandom_range(0, 32'hFFFFFF)) - (longint'(1) << 23);
      endcase
    end
    d = model_symbol();
    for (int i = 0; i < SPS; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        prod_in    = PW'($urandom);
        prod_valid = 1'b0;
        @(posedge clk); #1;
      end
      prod_in    = PW'(samp[i]);
      prod_valid = 1'b1;
      @(posedge clk); #1;
      prod_valid = 1'b0;
      prod_in    = PW'($urandom);
    end
    model_bit(d);
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_symbol(0, v[i]);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bit_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", (n < 2000) ? 1 : 0, 1);
  endtask

  // ready generator: never stays low long enough to overflow in random mode
  initial begin
    int low_run = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) bit_ready = 1'b0;
      else if (rdy_mode == 1 || low_run >= 6) bit_ready = 1'b1;
      else bit_ready = ($urandom_range(0, 3) != 0);
      low_run = bit_ready ? 0 : low_run + 1;
    end
  end

  // monitor: pops the scoreboard on each accepted bit
  initial begin
    bit prev_stall = 1'b0;
    bit prev_bit = 1'b0;
    bit prev_fs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && enable) begin
        if (prev_stall) begin
          chk("stall_valid", bit_valid, 1);
          chk("stall_data", bit_out, prev_bit);
        end
        if (bit_valid && bit_ready) begin
          if (sb.size() == 0) chk("unexpected_bit", 1, 0);
          else chk("payload_bit", bit_out, sb.pop_front());
        end
        if (frame_start) begin
          fs_seen++;
          chk("fs_single_cycle", prev_fs, 0);
          chk("fs_active", frame_active, 1);
        end
      end
      prev_fs    = frame_start;
      prev_stall = bit_valid && !bit_ready && enable && !rst;
      prev_bit   = bit_out;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    chk("idle_to_hunt", state_o, 1);

    // decision basics and alternating payload with ready held high
    rdy_mode = 1;
    send_byte(8'hA5, 8);
    send_symbol(1, 1'b1);
    @(negedge clk); chk("latency_n1_empty", bit_valid, 0);
    @(negedge clk); chk("latency_n2_valid", bit_valid, 1);
    send_symbol(1, 1'b0);
    send_symbol(2, 1'b0);
    send_symbol(3, 1'b1);
    for (int i = 4; i < 64; i++) send_symbol(0, (i % 2) == 0);
    settle();
    chk("frame1_fs_count", fs_seen, exp_fs);
    chk("frame1_back_to_hunt", state_o, 1);
    chk("frame1_active_low", frame_active, 0);
    wait_drain();

    // A4 followed by A5 must only match on the final A5 symbol
    rdy_mode = 0;
    send_byte(8'hA4, 8);
    send_byte(8'hA5, 7);
    settle();
    chk("a4a5_no_early_fs", fs_seen, exp_fs);
    chk("a4a5_still_hunt", state_o, 1);
    send_symbol(0, 1'b1);
    settle();
    chk("a4a5_fs", fs_seen, exp_fs);
    chk("a4a5_payload_state", state_o, 2);
    for (int i = 0; i < 64; i++) send_symbol(($urandom_range(0, 3) == 0) ? 4 : 0, 1'($urandom));
    settle();
    wait_drain();

    // overflow: downstream stalled for a whole frame
    rdy_mode = 2;
    m_occ = 0;
    send_byte(8'hA5, 8);
    for (int i = 0; i < 64; i++) send_symbol(0, 1'($urandom));
    settle();
    chk("ovf_set", overflow, 1);
    chk("ovf_buffer_held", bit_valid, 1);
    chk("ovf_hunt", state_o, 1);
    rdy_mode = 1;
    wait_drain();
    chk("ovf_sticky", overflow, 1);

    // enable dropped mid-frame after 20 payload bits
    send_byte(8'hA5, 8);
    for (int i = 0; i < 20; i++) send_symbol(0, 1'($urandom));
    wait_drain();
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    m_hunt = 1'b1;
    m_win  = '0;
    m_pay  = 0;
    @(negedge clk);
    chk("dis_idle", state_o, 0);
    chk("dis_bit_valid", bit_valid, 0);
    chk("dis_overflow", overflow, 0);
    chk("dis_frame_active", frame_active, 0);
    @(posedge clk); #1;
    chk("reen_hunt", state_o, 1);

    // randomized frames with leading noise symbols
    rdy_mode = 0;
    for (int f = 0; f < 3; f++) begin
      int nz = $urandom_range(0, 12);
      for (int i = 0; i < nz; i++) send_symbol(4, 1'b0);
      send_byte(8'hA5, 8);
      for (int i = 0; i < 64; i++) send_symbol($urandom_range(0, 4), 1'($urandom));
    end
    settle();
    wait_drain();
    chk("final_fs_count", fs_seen, exp_fs);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
